hough_list_requester: RTL and testbench
=======================================

// Module: hough_list_requester
// PURPOSE
//  Initiator side of the Hough linked-list request interface (append/search/show + done).
//  Accepts queued commands from the voting/peak-extraction logic and drives the list's request strobes.
//  Waits on done, then returns one response per list transaction.
//  DUMP walks param addresses 0..N-1 with show requests, so upstream never sequences the list by hand.
// PARAMETERS
//  RHO_W    10  width of rho values
//  ADDR_W   12  width of param (theta bucket) address
//  NODE_W   32  width of node word returned by list
//  TIMEOUT  16  max WAIT cycles for done before aborting a transaction (>=2)
// PORTS
//  clk            in   1       clock, all logic on rising edge
//  rst            in   1       synchronous reset, active-high
//  cmd_valid_i    in   1       command offered
//  cmd_ready_o    out  1       command accepted when valid&ready
//  cmd_op_i       in   2       0=APPEND 1=SEARCH 2=SHOW 3=DUMP
//  cmd_rho_i      in   RHO_W   rho for APPEND/SEARCH
//  cmd_addr_i     in   ADDR_W  SHOW: address; DUMP: count N (0 => no transaction)
//  append_o       out  1       1-cycle append strobe to list
//  search_o       out  1       1-cycle search strobe to list
//  show_o         out  1       1-cycle show strobe to list
//  rho_o          out  RHO_W   rho presented with strobe, held until done
//  param_addr_o   out  ADDR_W  address presented with show strobe, held until done
//  done_i         in   1       list transaction complete
//  append_ack_i   in   1       list reports new node created (valid with done_i)
//  found_i        in   1       list reports rho found (valid with done_i)
//  node_i         in   NODE_W  node word (valid with done_i)
//  rsp_valid_o    out  1       response available
//  rsp_ready_i    in   1       response consumed when valid&ready
//  rsp_op_o       out  2      op of this response (DUMP entries report 3)
//  rsp_addr_o     out  ADDR_W  address of SHOW/DUMP response, else 0
//  rsp_flag_o     out  1       APPEND: append_ack_i; SEARCH: found_i; SHOW/DUMP: 1
//  rsp_node_o     out  NODE_W  captured node_i
//  rsp_timeout_o  out  1       transaction aborted on TIMEOUT; flag/node forced 0
//  busy_o         out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, counters 0; cmd_ready_o rises the cycle after rst falls.
//  FSM states: IDLE, ISSUE, WAIT, RESP.
//  IDLE: cmd_ready_o=1. Accept -> latch op/rho/addr.
//    DUMP with N=0: no transaction, stay IDLE. Any other accept -> ISSUE.
//  ISSUE: exactly one strobe for one cycle (DUMP uses show_o, addr=cur index); -> WAIT.
//  WAIT: done_i ignored during ISSUE cycle, sampled from next cycle on.
//    done_i=1 -> capture flag/node -> RESP.
//    TIMEOUT cycles without done -> RESP, rsp_timeout_o=1.
//    done_i and timeout same cycle: done wins.
//  RESP: rsp_valid_o held, payload stable until rsp_ready_i. On handshake:
//    DUMP and index<N-1: index++ -> ISSUE.
//    Else -> IDLE.
//    Timeout during DUMP continues walk; each entry flagged independently.
//  Latency: accept->strobe 1 cycle; done->rsp_valid 1 cycle; no overlap; one transaction outstanding max.
//  cmd_ready_o=0 outside IDLE. rho_o/param_addr_o zeroed on return to IDLE.
//  Stray done_i in IDLE/ISSUE/RESP is ignored.
//  Index counter ADDR_W bits: N=2^ADDR_W-1 is the max walk, no wrap.
//  rst mid-transaction: aborts immediately, no response emitted, outputs to reset values.
// STRUCTURE
//  hough_list_pkg: op encodings, FSM state enum, RHO_W/ADDR_W/NODE_W defaults (shared with HT list).
//  Single module; timeout counter inline, no sub-module.
// TESTING (bench pairs requester with behavioural list model, done 3 cycles after strobe)
//  APPEND rho=123 twice, ack 1 then 0 -> two rsp op=0 flag=1 then flag=0; append_o 1 cycle each.
//  SEARCH 789 (found=0), SEARCH 321 (found=1, node=0x00010141) -> flag 0 then 1, node captured.
//  DUMP N=10 -> show_o at addr 0..9 in order, 10 responses op=3 addr 0..9, then ready.
//  DUMP N=0 -> no strobe, no response, cmd_ready_o stays 1.
//  Model never asserts done -> rsp after exactly TIMEOUT WAIT cycles, timeout=1, node=0.
//  rsp_ready_i held 0 for 5 cycles in DUMP -> payload stable, no further strobe.
//  rst high mid-WAIT -> all outputs 0 next cycle, then ready.
//  done_i pulse in IDLE -> no response.

Source files
------------

// File: rtl/hough_list_pkg.sv
// Shared definitions for the Hough linked-list interface.
//   - Default widths for rho values, param (theta bucket) addresses and node words.
//   - Command/response op encodings.
//   - Requester FSM state encoding.
// Imported by the requester and by the list itself so both agree on encodings.
package hough_list_pkg;

    localparam int RHO_W_DEF  = 10;
    localparam int ADDR_W_DEF = 12;
    localparam int NODE_W_DEF = 32;

    typedef enum logic [1:0] {
        OP_APPEND = 2'd0,
        OP_SEARCH = 2'd1,
        OP_SHOW   = 2'd2,
        OP_DUMP   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    // SHOW and DUMP are the only ops whose responses carry an address.
    function automatic logic op_has_addr(input op_e op);
        return (op == OP_SHOW) || (op == OP_DUMP);
    endfunction

endpackage

// File: rtl/hough_list_requester.sv
// Initiator side of the Hough linked-list request interface.
// Takes one command at a time from upstream, drives a single one-cycle request
// strobe (append/search/show) to the list, waits for done (or a timeout) and
// returns one response per list transaction. A DUMP command walks param
// addresses 0..N-1 with show requests, one response per address.
//
// Ports
//   clk, rst                         clock; synchronous active-high reset
//   cmd_valid_i/cmd_ready_o          command handshake (ready only in IDLE)
//   cmd_op_i, cmd_rho_i, cmd_addr_i  op, rho (APPEND/SEARCH), address or DUMP count
//   append_o, search_o, show_o       one-cycle request strobes to the list
//   rho_o, param_addr_o              request operands, held until the list replies
//   done_i, append_ack_i, found_i,
//   node_i                           list completion and result fields
//   rsp_valid_o/rsp_ready_i          response handshake
//   rsp_op_o, rsp_addr_o, rsp_flag_o,
//   rsp_node_o, rsp_timeout_o        response payload
//   busy_o                           FSM is not in IDLE
module hough_list_requester
    import hough_list_pkg::*;
#(
    parameter int RHO_W   = RHO_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int NODE_W  = NODE_W_DEF,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [1:0]        cmd_op_i,
    input  logic [RHO_W-1:0]  cmd_rho_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    output logic              append_o,
    output logic              search_o,
    output logic              show_o,
    output logic [RHO_W-1:0]  rho_o,
    output logic [ADDR_W-1:0] param_addr_o,
    input  logic              done_i,
    input  logic              append_ack_i,
    input  logic              found_i,
    input  logic [NODE_W-1:0] node_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [1:0]        rsp_op_o,
    output logic [ADDR_W-1:0] rsp_addr_o,
    output logic              rsp_flag_o,
    output logic [NODE_W-1:0] rsp_node_o,
    output logic              rsp_timeout_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_e              state_q, state_d;
    op_e                 op_q;
    op_e                 cmd_op;
    logic                ready_q;
    logic [RHO_W-1:0]    rho_q;
    logic [ADDR_W-1:0]   addr_q;   // SHOW address, or current DUMP index
    logic [ADDR_W-1:0]   count_q;  // DUMP length N
    logic [CNT_W-1:0]    wait_q;
    logic [1:0]          rsp_op_q;
    logic [ADDR_W-1:0]   rsp_addr_q;
    logic                rsp_flag_q;
    logic [NODE_W-1:0]   rsp_node_q;
    logic                rsp_timeout_q;

    logic cmd_fire, rsp_fire, wait_expired, dump_more, dump_empty;

    assign cmd_op       = op_e'(cmd_op_i);
    // ready_q (not just the state) gates acceptance so nothing is taken in
    // the first cycle after reset, while cmd_ready_o is still low.
    assign cmd_fire     = (state_q == ST_IDLE) && ready_q && cmd_valid_i;
    assign rsp_fire     = (state_q == ST_RESP) && rsp_ready_i;
    assign wait_expired = (wait_q == CNT_W'(TIMEOUT - 1));
    assign dump_empty   = (cmd_op == OP_DUMP) && (cmd_addr_i == '0);
    // count_q >= 1 whenever a DUMP is in flight, so count_q-1 cannot wrap.
    assign dump_more    = (op_q == OP_DUMP) && (addr_q < (count_q - ADDR_W'(1)));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: state_d gets its default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (cmd_fire && !dump_empty) state_d = ST_ISSUE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT:  if (done_i || wait_expired) state_d = ST_RESP;
            ST_RESP:  if (rsp_fire) state_d = dump_more ? ST_ISSUE : ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q       <= 1'b0;
            op_q          <= OP_APPEND;
            rho_q         <= '0;
            addr_q        <= '0;
            count_q       <= '0;
            wait_q        <= '0;
            rsp_op_q      <= '0;
            rsp_addr_q    <= '0;
            rsp_flag_q    <= 1'b0;
            rsp_node_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            ready_q <= (state_d == ST_IDLE);
            unique case (state_q)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        op_q    <= cmd_op;
                        count_q <= cmd_addr_i;
                        rho_q   <= (cmd_op == OP_APPEND || cmd_op == OP_SEARCH) ? cmd_rho_i : '0;
                        addr_q  <= (cmd_op == OP_SHOW) ? cmd_addr_i : '0;
                    end
                end
                ST_ISSUE: wait_q <= '0;
                ST_WAIT: begin
                    if (done_i || wait_expired) begin
                        rsp_op_q   <= op_q;
                        rsp_addr_q <= op_has_addr(op_q) ? addr_q : '0;
                        // A done arriving on the last allowed cycle still wins.
                        if (done_i) begin
                            rsp_timeout_q <= 1'b0;
                            rsp_node_q    <= node_i;
                            unique case (op_q)
                                OP_APPEND: rsp_flag_q <= append_ack_i;
                                OP_SEARCH: rsp_flag_q <= found_i;
                                default:   rsp_flag_q <= 1'b1;
                            endcase
                        end else begin
                            rsp_timeout_q <= 1'b1;
                            rsp_node_q    <= '0;
                            rsp_flag_q    <= 1'b0;
                        end
                    end else begin
                        wait_q <= wait_q + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_fire) begin
                        rsp_op_q      <= '0;
                        rsp_addr_q    <= '0;
                        rsp_flag_q    <= 1'b0;
                        rsp_node_q    <= '0;
                        rsp_timeout_q <= 1'b0;
                        if (dump_more) begin
                            addr_q <= addr_q + ADDR_W'(1);
                        end else begin
                            rho_q  <= '0;
                            addr_q <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready_o   = ready_q;
    assign append_o      = (state_q == ST_ISSUE) && (op_q == OP_APPEND);
    assign search_o      = (state_q == ST_ISSUE) && (op_q == OP_SEARCH);
    assign show_o        = (state_q == ST_ISSUE) && op_has_addr(op_q);
    assign rho_o         = rho_q;
    assign param_addr_o  = addr_q;
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_op_o      = rsp_op_q;
    assign rsp_addr_o    = rsp_addr_q;
    assign rsp_flag_o    = rsp_flag_q;
    assign rsp_node_o    = rsp_node_q;
    assign rsp_timeout_o = rsp_timeout_q;
    assign busy_o        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_hough_list_requester.sv
// Directed bench for hough_list_requester, paired with a behavioural list
// model that raises done three cycles after each request strobe. Expected
// strobes and responses are queued as each command is driven and compared
// against what the monitors collect from the DUT.
module tb_hough_list_requester;

    localparam int RHO_W   = 10;
    localparam int ADDR_W  = 12;
    localparam int NODE_W  = 32;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid_i;
    logic              cmd_ready_o;
    logic [1:0]        cmd_op_i;
    logic [RHO_W-1:0]  cmd_rho_i;
    logic [ADDR_W-1:0] cmd_addr_i;
    logic              append_o, search_o, show_o;
    logic [RHO_W-1:0]  rho_o;
    logic [ADDR_W-1:0] param_addr_o;
    logic              done_i;
    logic              append_ack_i = 1'b0;
    logic              found_i      = 1'b0;
    logic [NODE_W-1:0] node_i       = '0;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [1:0]        rsp_op_o;
    logic [ADDR_W-1:0] rsp_addr_o;
    logic              rsp_flag_o;
    logic [NODE_W-1:0] rsp_node_o;
    logic              rsp_timeout_o;
    logic              busy_o;

    hough_list_requester #(
        .RHO_W(RHO_W), .ADDR_W(ADDR_W), .NODE_W(NODE_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_op_i(cmd_op_i), .cmd_rho_i(cmd_rho_i), .cmd_addr_i(cmd_addr_i),
        .append_o(append_o), .search_o(search_o), .show_o(show_o),
        .rho_o(rho_o), .param_addr_o(param_addr_o),
        .done_i(done_i), .append_ack_i(append_ack_i), .found_i(found_i), .node_i(node_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_op_o(rsp_op_o), .rsp_addr_o(rsp_addr_o), .rsp_flag_o(rsp_flag_o),
        .rsp_node_o(rsp_node_o), .rsp_timeout_o(rsp_timeout_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]        kind;   // {show, search, append}
        logic [RHO_W-1:0]  rho;
        logic [ADDR_W-1:0] addr;
    } stb_t;

    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
        logic              flag;
        logic [NODE_W-1:0] node;
        logic              to;
    } rsp_t;

    typedef struct { stb_t s; int cyc; } stb_rec_t;
    typedef struct { rsp_t r; int cyc; } rsp_rec_t;

    stb_t     exp_stb[$];
    rsp_t     exp_rsp[$];
    stb_rec_t got_stb[$];
    rsp_rec_t got_rsp[$];
    int       rd_stb = 0;
    int       rd_rsp = 0;
    int       total  = 0;
    int       bad    = 0;
    int       cyc    = 0;
    int       unstable = 0;

    // List model configuration, written only by the stimulus block.
    logic              cfg_ack   = 1'b0;
    logic              cfg_found = 1'b0;
    logic [NODE_W-1:0] cfg_node  = '0;
    logic              cfg_never = 1'b0;
    logic              model_done = 1'b0;
    logic              stray_done = 1'b0;
    assign done_i = model_done | stray_done;

    always @(posedge clk) cyc++;

    // Behavioural list: done (with result fields) three cycles after a strobe.
    int                m_dly  = 0;
    logic              m_show = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    always @(posedge clk) begin
        #1;
        model_done   = 1'b0;
        append_ack_i = 1'b0;
        found_i      = 1'b0;
        node_i       = '0;
        if (m_dly > 0) begin
            m_dly--;
            if (m_dly == 0) begin
                model_done   = 1'b1;
                append_ack_i = cfg_ack;
                found_i      = cfg_found;
                node_i       = m_show ? (32'hA000_0000 | NODE_W'(m_addr)) : cfg_node;
            end
        end
        if ((append_o || search_o || show_o) && !cfg_never) begin
            m_dly  = 3;
            m_show = show_o;
            m_addr = param_addr_o;
        end
    end

    // Monitors: collect strobes and handshaken responses, check payload hold.
    logic prev_hold = 1'b0;
    rsp_t prev_pay;
    always @(negedge clk) begin
        rsp_t cur;
        cur = '{op: rsp_op_o, addr: rsp_addr_o, flag: rsp_flag_o, node: rsp_node_o, to: rsp_timeout_o};
        if (append_o || search_o || show_o)
            got_stb.push_back('{s: '{kind: {show_o, search_o, append_o}, rho: rho_o, addr: param_addr_o}, cyc: cyc});
        if (rsp_valid_o) begin
            if (prev_hold && cur != prev_pay) unstable++;
            if (rsp_ready_i) begin
                got_rsp.push_back('{r: cur, cyc: cyc});
                prev_hold = 1'b0;
            end else begin
                prev_hold = 1'b1;
                prev_pay  = cur;
            end
        end else begin
            prev_hold = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] op, input logic [RHO_W-1:0] rho,
                        input logic [ADDR_W-1:0] addr, output int acc);
        int n;
        n = 0;
        @(posedge clk); #1;
        cmd_valid_i = 1'b1; cmd_op_i = op; cmd_rho_i = rho; cmd_addr_i = addr;
        do begin @(negedge clk); n++; end while (!cmd_ready_o && n < 50);
        check("cmd_accepted", cmd_ready_o, 1);
        acc = cyc;
        @(posedge clk); #1;
        cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_rho_i = '0; cmd_addr_i = '0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin @(negedge clk); n++; end while (busy_o && n < budget);
        check("idle_reached", busy_o, 0);
    endtask

    task automatic compare_all(input string tag);
        stb_t es;
        rsp_t er;
        check({tag, "_stb_count"}, 64'(got_stb.size() - rd_stb), 64'(exp_stb.size()));
        while (exp_stb.size() > 0 && rd_stb < got_stb.size()) begin
            es = exp_stb.pop_front();
            check({tag, "_stb"}, 64'(got_stb[rd_stb].s), 64'(es));
            rd_stb++;
        end
        exp_stb.delete();
        rd_stb = got_stb.size();
        check({tag, "_rsp_count"}, 64'(got_rsp.size() - rd_rsp), 64'(exp_rsp.size()));
        while (exp_rsp.size() > 0 && rd_rsp < got_rsp.size()) begin
            er = exp_rsp.pop_front();
            check({tag, "_rsp"}, 64'(got_rsp[rd_rsp].r), 64'(er));
            rd_rsp++;
        end
        exp_rsp.delete();
        rd_rsp = got_rsp.size();
    endtask

    // Cycle distances acc->strobe and strobe->response for the next pending records.
    task automatic check_latency(input string tag, input int acc, input int rsp_lat);
        int l1, l2;
        l1 = -1; l2 = -1;
        if (got_stb.size() > rd_stb) l1 = got_stb[rd_stb].cyc - acc;
        if (got_stb.size() > rd_stb && got_rsp.size() > rd_rsp)
            l2 = got_rsp[rd_rsp].cyc - got_stb[rd_stb].cyc;
        check({tag, "_acc_to_strobe"}, 64'(l1), 64'(1));
        check({tag, "_strobe_to_rsp"}, 64'(l2), 64'(rsp_lat));
    endtask

    function automatic logic out_any();
        return cmd_ready_o | append_o | search_o | show_o | (|rho_o) | (|param_addr_o) |
               rsp_valid_o | (|rsp_op_o) | (|rsp_addr_o) | rsp_flag_o | (|rsp_node_o) |
               rsp_timeout_o | busy_o;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc, n, cnt;
        rst = 1'b1; cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_rho_i = '0; cmd_addr_i = '0;
        rsp_ready_i = 1'b1;

        // Reset state and ready timing after release.
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", out_any(), 0);
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        check("ready_low_release_cycle", cmd_ready_o, 0);
        @(negedge clk);
        check("ready_high_after_release", cmd_ready_o, 1);

        // APPEND rho=123 twice: ack 1 then 0.
        cfg_ack = 1'b1; cfg_node = 32'h0000_0011;
        exp_stb.push_back('{kind: 3'b001, rho: 10'd123, addr: '0});
        exp_rsp.push_back('{op: 2'd0, addr: '0, flag: 1'b1, node: 32'h0000_0011, to: 1'b0});
        send(2'd0, 10'd123, '0, acc);
        wait_idle(40);
        check_latency("append1", acc, 4);
        compare_all("append1");
        check("rho_cleared_idle", rho_o, 0);
        cfg_ack = 1'b0; cfg_node = 32'h0000_0022;
        exp_stb.push_back('{kind: 3'b001, rho: 10'd123, addr: '0});
        exp_rsp.push_back('{op: 2'd0, addr: '0, flag: 1'b0, node: 32'h0000_0022, to: 1'b0});
        send(2'd0, 10'd123, '0, acc);
        wait_idle(40);
        compare_all("append2");

        // SEARCH 789 not found, SEARCH 321 found.
        cfg_found = 1'b0; cfg_node = '0;
        exp_stb.push_back('{kind: 3'b010, rho: 10'd789, addr: '0});
        exp_rsp.push_back('{op: 2'd1, addr: '0, flag: 1'b0, node: '0, to: 1'b0});
        send(2'd1, 10'd789, '0, acc);
        wait_idle(40);
        compare_all("search_miss");
        cfg_found = 1'b1; cfg_node = 32'h0001_0141;
        exp_stb.push_back('{kind: 3'b010, rho: 10'd321, addr: '0});
        exp_rsp.push_back('{op: 2'd1, addr: '0, flag: 1'b1, node: 32'h0001_0141, to: 1'b0});
        send(2'd1, 10'd321, '0, acc);
        wait_idle(40);
        compare_all("search_hit");
        cfg_found = 1'b0;

        // SHOW at a single address.
        exp_stb.push_back('{kind: 3'b100, rho: '0, addr: 12'h05A});
        exp_rsp.push_back('{op: 2'd2, addr: 12'h05A, flag: 1'b1, node: 32'hA000_005A, to: 1'b0});
        send(2'd2, '0, 12'h05A, acc);
        wait_idle(40);
        compare_all("show");
        check("addr_cleared_idle", param_addr_o, 0);

        // DUMP N=10, with the first response stalled for 5 cycles.
        for (int i = 0; i < 10; i++) begin
            exp_stb.push_back('{kind: 3'b100, rho: '0, addr: ADDR_W'(i)});
            exp_rsp.push_back('{op: 2'd3, addr: ADDR_W'(i), flag: 1'b1,
                                node: 32'hA000_0000 | NODE_W'(i), to: 1'b0});
        end
        rsp_ready_i = 1'b0;
        send(2'd3, '0, 12'd10, acc);
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid_o && n < 40);
        check("dump_first_rsp_seen", rsp_valid_o, 1);
        cnt = got_stb.size();
        n = 0;
        repeat (5) begin
            @(negedge clk);
            if (!rsp_valid_o) n++;
        end
        check("hold_valid_kept", 64'(n), 0);
        check("hold_no_strobe", 64'(got_stb.size() - cnt), 0);
        check("hold_payload_stable", 64'(unstable), 0);
        @(posedge clk); #1; rsp_ready_i = 1'b1;
        wait_idle(300);
        compare_all("dump10");
        @(negedge clk);
        check("ready_after_dump", cmd_ready_o, 1);

        // DUMP N=0: no transaction, ready never drops.
        send(2'd3, '0, '0, acc);
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (!cmd_ready_o || busy_o || show_o) cnt++;
        end
        check("dump0_stays_idle", 64'(cnt), 0);
        compare_all("dump0");

        // List never answers: timeout response after exactly TIMEOUT WAIT cycles.
        cfg_never = 1'b1; cfg_node = 32'hDEAD_BEEF; cfg_found = 1'b1;
        exp_stb.push_back('{kind: 3'b010, rho: 10'd5, addr: '0});
        exp_rsp.push_back('{op: 2'd1, addr: '0, flag: 1'b0, node: '0, to: 1'b1});
        send(2'd1, 10'd5, '0, acc);
        wait_idle(100);
        check_latency("timeout", acc, TIMEOUT + 1);
        compare_all("timeout");

        // Reset in the middle of WAIT: abort, no response.
        exp_stb.push_back('{kind: 3'b001, rho: 10'd77, addr: '0});
        send(2'd0, 10'd77, '0, acc);
        repeat (2) @(negedge clk);
        check("midwait_busy", busy_o, 1);
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midwait_reset_outputs_zero", out_any(), 0);
        @(posedge clk); #1; rst = 1'b0;
        cfg_never = 1'b0; cfg_found = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("ready_after_midwait_reset", cmd_ready_o, 1);
        compare_all("midwait_reset");

        // Stray done pulse while idle.
        @(posedge clk); #1; stray_done = 1'b1;
        @(posedge clk); #1; stray_done = 1'b0;
        repeat (4) @(negedge clk);
        check("stray_done_not_busy", busy_o, 0);
        compare_all("stray_done");

        // Normal operation resumes.
        cfg_found = 1'b1; cfg_node = 32'h0000_0ABC;
        exp_stb.push_back('{kind: 3'b010, rho: 10'd1023, addr: '0});
        exp_rsp.push_back('{op: 2'd1, addr: '0, flag: 1'b1, node: 32'h0000_0ABC, to: 1'b0});
        send(2'd1, 10'd1023, '0, acc);
        wait_idle(40);
        check_latency("final", acc, 4);
        compare_all("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
